// File: rtl/wb_pkg.sv
// Shared bus widths and responder state encodings for the Wishbone memory slave.
package wb_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_SELW = WB_DW / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

endpackage

// File: rtl/wb_sp_ram.sv
// Single-port synchronous RAM with per-byte write enables.
module wb_sp_ram
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = 10,
  parameter string       MEM_INIT = ""
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic [WB_SELW-1:0] we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [WB_DW-1:0]   din_i,
  output logic [WB_DW-1:0]   dout_o
);

  logic [WB_DW-1:0] mem_q [DEPTH];
  logic [WB_DW-1:0] dout_q;

  // Read-before-write: dout reflects the word as it was before this edge's write.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int unsigned b = 0; b < WB_SELW; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= din_i[8*b +: 8];
      end
      dout_q <= mem_q[addr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic-cycle memory responder with programmable wait states and
// error termination on misaligned or out-of-range addresses.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned      DEPTH_WORDS = 1024,
  parameter int unsigned      WAIT_STATES = 0,
  parameter string            MEM_INIT    = ""
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WB_AW-1:0]   wbs_addr_i,
  input  logic [WB_DW-1:0]   wbs_dat_i,
  input  logic [WB_SELW-1:0] wbs_sel_i,
  input  logic               wbs_we_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  output logic [WB_DW-1:0]   wbs_dat_o,
  output logic               wbs_ack_o,
  output logic               wbs_err_o
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [32:0] END_EXT  = BASE_EXT + (33'(DEPTH_WORDS) << 2);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             req;
  logic             addr_bad;
  logic [32:0]      addr_ext;
  logic [IDX_W-1:0] word_idx;
  logic             ram_access;
  logic             ram_en;
  logic [WB_DW-1:0] ram_dout;

  assign req      = wbs_cyc_i & wbs_stb_i;
  // 33-bit compare keeps the top-of-memory bound from wrapping to zero.
  assign addr_ext = {1'b0, wbs_addr_i};
  assign addr_bad = (wbs_addr_i[1:0] != 2'b00) || (addr_ext < BASE_EXT) || (addr_ext >= END_EXT);
  assign word_idx = IDX_W'((wbs_addr_i - BASE_ADDR) >> 2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (addr_bad) begin
            state_d = ST_ERR;
          end else if (WAIT_STATES == 0) begin
            state_d    = ST_RESP;
            ram_access = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d    = ST_RESP;
          ram_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A reset edge must never commit a write, even when it coincides with RESP entry.
  assign ram_en = ram_access & ~rst_i;

  wb_sp_ram #(
    .DEPTH    (DEPTH_WORDS),
    .AW       (IDX_W),
    .MEM_INIT (MEM_INIT)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   ({WB_SELW{wbs_we_i}} & wbs_sel_i),
    .addr_i (word_idx),
    .din_i  (wbs_dat_i),
    .dout_o (ram_dout)
  );

  assign wbs_ack_o = (state_q == ST_RESP);
  assign wbs_err_o = (state_q == ST_ERR);
  assign wbs_dat_o = wbs_ack_o ? ram_dout : '0;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Bench for wb_mem_slave: two instances (zero and three wait states) checked
// against an array-based memory model plus directed corner-case sequences.
module tb_wb_mem_slave;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0][31:0] addr_s, datw_s, datr_s;
  logic [1:0][3:0]  sel_s;
  logic [1:0]       we_s, cyc_s, stb_s, ack_s, err_s;

  int total = 0;
  int bad   = 0;

  logic [31:0] BASE [2] = '{32'hFFFF_F000, 32'h0000_2000};
  int          DEP  [2] = '{1024, 64};
  int          WS   [2] = '{0, 3};
  logic [31:0] mm   [2][1024];

  always #5 clk = ~clk;

  wb_mem_slave #(.BASE_ADDR(32'hFFFF_F000), .DEPTH_WORDS(1024), .WAIT_STATES(0), .MEM_INIT("")) u_dut0 (
    .clk_i(clk), .rst_i(rst), .wbs_addr_i(addr_s[0]), .wbs_dat_i(datw_s[0]), .wbs_sel_i(sel_s[0]),
    .wbs_we_i(we_s[0]), .wbs_cyc_i(cyc_s[0]), .wbs_stb_i(stb_s[0]), .wbs_dat_o(datr_s[0]),
    .wbs_ack_o(ack_s[0]), .wbs_err_o(err_s[0]));

  wb_mem_slave #(.BASE_ADDR(32'h0000_2000), .DEPTH_WORDS(64), .WAIT_STATES(3), .MEM_INIT("")) u_dut1 (
    .clk_i(clk), .rst_i(rst), .wbs_addr_i(addr_s[1]), .wbs_dat_i(datw_s[1]), .wbs_sel_i(sel_s[1]),
    .wbs_we_i(we_s[1]), .wbs_cyc_i(cyc_s[1]), .wbs_stb_i(stb_s[1]), .wbs_dat_o(datr_s[1]),
    .wbs_ack_o(ack_s[1]), .wbs_err_o(err_s[1]));

  typedef struct {
    int          d;
    logic [31:0] a;
    logic        w;
    logic [3:0]  s;
    logic [31:0] wd;
    logic        e;
    logic        usex;
    logic [31:0] xd;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic model_bad(input int d, input logic [31:0] a);
    longint ae, lo, hi;
    ae = longint'(a);
    lo = longint'(BASE[d]);
    hi = lo + 4 * longint'(DEP[d]);
    return (a[1:0] != 2'b00) || (ae < lo) || (ae >= hi);
  endfunction

  function automatic int model_idx(input int d, input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE[d])) / 4);
  endfunction

  task automatic model_wr(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
    int i;
    i = model_idx(d, a);
    for (int b = 0; b < 4; b++) if (s[b]) mm[d][i][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic idle_bus(input int d);
    cyc_s[d] = 1'b0; stb_s[d] = 1'b0; we_s[d] = 1'b0;
  endtask

  // One classic transfer; latency counted in cycles after the sampling edge.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] wd, output int lat, output logic gerr, output logic [31:0] rd);
    @(negedge clk);
    addr_s[d] = a; we_s[d] = w; sel_s[d] = s; datw_s[d] = wd;
    cyc_s[d] = 1'b1; stb_s[d] = 1'b1;
    lat = 0; gerr = 1'b0; rd = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack_s[d] && err_s[d]) chk("ack_err_excl", 32'(1), 32'(0));
      if (ack_s[d] || err_s[d]) begin
        lat = k; gerr = err_s[d]; rd = datr_s[d];
        break;
      end
    end
    idle_bus(d);
    if (lat == 0) chk("timeout", 32'(0), 32'(1));
    @(negedge clk);
    chk("pulse_width", {30'b0, ack_s[d], err_s[d]}, 32'(0));
  endtask

  task automatic op(input int d, input logic [31:0] a, input logic w, input logic [3:0] s,
                    input logic [31:0] wd, input logic exp_e, input logic usex, input logic [31:0] xd,
                    input string tag);
    int          lat;
    logic        ge;
    logic [31:0] rd;
    xfer(d, a, w, s, wd, lat, ge, rd);
    chk({tag, " err"}, 32'(ge), 32'(exp_e));
    chk({tag, " lat"}, 32'(lat), exp_e ? 32'(1) : 32'(WS[d] + 1));
    if (exp_e) chk({tag, " errdat"}, rd, '0);
    else if (!w) chk({tag, " rdat"}, rd, usex ? xd : mm[d][model_idx(d, a)]);
    if (!exp_e && w) model_wr(d, a, s, wd);
  endtask

  task automatic quiet(input int d, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk(tag, {30'b0, ack_s[d], err_s[d]}, 32'(0));
    end
  endtask

  // IF-style burst: cyc/stb stay high, address advances after every ack.
  task automatic b2b(input int d, input logic [31:0] start);
    logic [31:0] a;
    int          n, last;
    a = start; n = 0; last = 0;
    @(negedge clk);
    addr_s[d] = a; we_s[d] = 1'b0; sel_s[d] = 4'hF; cyc_s[d] = 1'b1; stb_s[d] = 1'b1;
    for (int c = 1; c <= 200 && n < 8; c++) begin
      @(negedge clk);
      if (err_s[d]) chk("b2b err", 32'(1), 32'(0));
      if (ack_s[d]) begin
        chk("b2b data", datr_s[d], mm[d][model_idx(d, a)]);
        if (n > 0) chk("b2b spacing", 32'(c - last), 32'(WS[d] + 2));
        last = c; n++; a = a + 32'd4; addr_s[d] = a;
      end
    end
    idle_bus(d);
    chk("b2b count", 32'(n), 32'(8));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle_bus(d); addr_s[d] = '0; datw_s[d] = '0; sel_s[d] = '0;
    end

    tv.push_back('{0, 32'hFFFF_F010, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0});
    tv.push_back('{0, 32'hFFFF_F010, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
    tv.push_back('{0, 32'hFFFF_F020, 1'b1, 4'hF, 32'h11223344, 1'b0, 1'b0, 32'h0});
    tv.push_back('{0, 32'hFFFF_F020, 1'b1, 4'h5, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0});
    tv.push_back('{0, 32'hFFFF_F020, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'h11BB33DD});
    tv.push_back('{0, 32'hFFFF_F020, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0});
    tv.push_back('{0, 32'hFFFF_F020, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'h11BB33DD});
    tv.push_back('{0, 32'hFFFF_F000, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0});
    tv.push_back('{0, 32'hFFFF_F002, 1'b1, 4'hF, 32'h12345678, 1'b1, 1'b0, 32'h0});
    tv.push_back('{0, 32'hFFFF_F000, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D});
    tv.push_back('{0, 32'hFFFF_FFFC, 1'b1, 4'hF, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h0});
    tv.push_back('{0, 32'hFFFF_FFFC, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'h0F0F0F0F});
    tv.push_back('{0, 32'hFFFF_EFFC, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0});
    tv.push_back('{0, 32'h0000_0000, 1'b1, 4'hF, 32'h77777777, 1'b1, 1'b0, 32'h0});
    tv.push_back('{1, 32'h0000_2010, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0});
    tv.push_back('{1, 32'h0000_2010, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
    tv.push_back('{1, 32'h0000_2100, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0});
    tv.push_back('{1, 32'h0000_2100, 1'b1, 4'hF, 32'h99999999, 1'b1, 1'b0, 32'h0});
    tv.push_back('{1, 32'h0000_2000, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0});
    tv.push_back('{1, 32'h0000_20FC, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0});
    tv.push_back('{1, 32'h0000_1FFC, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0});
    tv.push_back('{1, 32'h0000_2003, 1'b1, 4'hF, 32'h55555555, 1'b1, 1'b0, 32'h0});

    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEP[d]; i++)
        op(d, BASE[d] + 32'(4 * i), 1'b1, 4'hF, $urandom, 1'b0, 1'b0, '0, "init");

    // Reset held 3 cycles with a write request pending: nothing may respond or commit.
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      addr_s[d] = BASE[d] + 32'h40; datw_s[d] = 32'h5555AAAA; sel_s[d] = 4'hF;
      we_s[d] = 1'b1; cyc_s[d] = 1'b1; stb_s[d] = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst ack", 32'(ack_s[d]), 32'(0));
        chk("rst err", 32'(err_s[d]), 32'(0));
        chk("rst dat", datr_s[d], '0);
      end
    end
    rst = 1'b0;
    for (int d = 0; d < 2; d++) idle_bus(d);
    for (int d = 0; d < 2; d++) op(d, BASE[d] + 32'h40, 1'b0, 4'h0, '0, 1'b0, 1'b0, '0, "post_rst");

    foreach (tv[i]) op(tv[i].d, tv[i].a, tv[i].w, tv[i].s, tv[i].wd, tv[i].e, tv[i].usex, tv[i].xd,
                       $sformatf("vec%0d", i));

    // Abort: stb dropped in the second wait cycle of a write.
    @(negedge clk);
    addr_s[1] = 32'h0000_2010; we_s[1] = 1'b1; sel_s[1] = 4'hF; datw_s[1] = 32'h0BAD0BAD;
    cyc_s[1] = 1'b1; stb_s[1] = 1'b1;
    quiet(1, 1, "abort w1");
    @(negedge clk);
    chk("abort w2", {30'b0, ack_s[1], err_s[1]}, 32'(0));
    stb_s[1] = 1'b0;
    quiet(1, 6, "abort quiet");
    idle_bus(1);
    op(1, 32'h0000_2010, 1'b0, 4'h0, '0, 1'b0, 1'b0, '0, "abort rd");

    // Reset arriving during wait states of a write.
    @(negedge clk);
    addr_s[1] = 32'h0000_2040; we_s[1] = 1'b1; sel_s[1] = 4'hF; datw_s[1] = 32'h1234ABCD;
    cyc_s[1] = 1'b1; stb_s[1] = 1'b1;
    quiet(1, 2, "midrst pre");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_bus(1);
    quiet(1, 6, "midrst quiet");
    op(1, 32'h0000_2040, 1'b0, 4'h0, '0, 1'b0, 1'b0, '0, "midrst rd");

    b2b(0, 32'hFFFF_F100);
    b2b(1, 32'h0000_2020);

    for (int n = 0; n < 200; n++) begin
      int          d;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = BASE[d] - 32'd4;
        1:       a = BASE[d] + 32'(4 * DEP[d]);
        2:       a = BASE[d] + 32'(4 * $urandom_range(0, DEP[d] - 1)) + 32'($urandom_range(1, 3));
        3:       a = $urandom;
        default: a = BASE[d] + 32'(4 * $urandom_range(0, DEP[d] - 1));
      endcase
      op(d, a, 1'($urandom), 4'($urandom), $urandom, model_bad(d, a), 1'b0, '0, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
